// File: rtl/clk_div_pkg.sv
// Shared constants, state type and ratio clamp for the clock divider controller.
package clk_div_pkg;

    localparam int K_WIDTH          = 8;
    localparam int K_DEFAULT        = 3;
    localparam int K_MIN            = 2;
    localparam int PERIOD_CNT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RUN       = 2'd1,
        STOP_PEND = 2'd2
    } state_t;

    function automatic logic [K_WIDTH-1:0] clamp_k(input logic [K_WIDTH-1:0] k);
        return (k < K_WIDTH'(K_MIN)) ? K_WIDTH'(K_MIN) : k;
    endfunction

endpackage

// File: rtl/div_counter.sv
// Modulo-k cycle counter with enable and synchronous clear; o_wrap is a
// combinational strobe, high in the cycle whose edge returns the count to 0.
module div_counter
    import clk_div_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_en,
    input  logic               i_clr,
    input  logic [K_WIDTH-1:0] i_k,
    output logic               o_wrap
);

    logic [K_WIDTH-1:0] r_count;
    logic               w_at_top;

    // >= rather than == keeps the counter safe if k ever shrinks under it.
    assign w_at_top = (r_count >= (i_k - K_WIDTH'(1)));
    assign o_wrap   = i_en & ~i_clr & w_at_top;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= w_at_top ? '0 : r_count + K_WIDTH'(1);
        end
    end

endmodule

// File: rtl/clk_div_ctrl.sv
// Start/stop controlled clock divider with a ratio handshake; half-period = k cycles.
// Optional derived-period counter on o_period_cnt when CLK_DIV_CTRL_PERIOD_CNT_EN is defined.
module clk_div_ctrl
    import clk_div_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic               i_stop,
    input  logic               i_k_valid,
    input  logic [K_WIDTH-1:0] i_k,
    output logic               o_k_ready,
    output logic               o_roll_over,
    output logic               o_clk_div,
    output logic               o_busy
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
    ,
    output logic [PERIOD_CNT_WIDTH-1:0] o_period_cnt
`endif
);

    state_t             r_state;
    state_t             w_next;
    logic [K_WIDTH-1:0] r_k_active;
    logic [K_WIDTH-1:0] r_k_pending;
    logic               r_k_ready;
    logic               r_roll_over;
    logic               r_clk_div;
    logic               r_busy;
    logic               w_wrap;
    logic               w_accept;
    logic               w_rise;
    logic               w_idle;

    assign w_idle   = (r_state == IDLE);
    assign w_accept = i_k_valid & r_k_ready;
    assign w_rise   = w_wrap & ~r_clk_div;

    div_counter u_div_counter (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_en    (~w_idle),
        .i_clr   (w_idle),
        .i_k     (r_k_active),
        .o_wrap  (w_wrap)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      if (i_start && !i_stop) w_next = RUN;
            RUN:       if (i_stop)             w_next = STOP_PEND;
            // Leave only on the low->high wrap so the derived clock rests high.
            STOP_PEND: if (w_rise)             w_next = IDLE;
            default:                           w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= IDLE;
            r_busy      <= 1'b0;
            r_roll_over <= 1'b0;
            r_clk_div   <= 1'b1;
            r_k_active  <= K_WIDTH'(K_DEFAULT);
            r_k_pending <= K_WIDTH'(K_DEFAULT);
            r_k_ready   <= 1'b1;
        end else begin
            r_state     <= w_next;
            r_busy      <= (w_next != IDLE);
            r_roll_over <= w_wrap;
            if (w_wrap) begin
                r_clk_div <= ~r_clk_div;
            end
            // Ratio only changes at a phase boundary, never mid-phase.
            if (w_idle || w_wrap) begin
                r_k_active <= r_k_pending;
            end
            if (w_accept) begin
                r_k_pending <= clamp_k(i_k);
            end
            if (w_accept && !w_idle) begin
                r_k_ready <= 1'b0;
            end else if (w_wrap || w_idle) begin
                r_k_ready <= 1'b1;
            end
        end
    end

`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
    logic [PERIOD_CNT_WIDTH-1:0] r_period_cnt;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_period_cnt <= '0;
        end else if (w_rise) begin
            r_period_cnt <= r_period_cnt + PERIOD_CNT_WIDTH'(1);
        end
    end

    assign o_period_cnt = r_period_cnt;
`endif

    assign o_k_ready   = r_k_ready;
    assign o_roll_over = r_roll_over;
    assign o_clk_div   = r_clk_div;
    assign o_busy      = r_busy;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Bench for clk_div_ctrl: directed scenarios plus random traffic against a flag-based reference model.
module tb_clk_div_ctrl;

    logic       i_clk = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_start = 1'b0;
    logic       i_stop = 1'b0;
    logic       i_k_valid = 1'b0;
    logic [7:0] i_k = 8'd3;
    logic       o_k_ready;
    logic       o_roll_over;
    logic       o_clk_div;
    logic       o_busy;
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
    logic [15:0] o_period_cnt;
`endif

    always #5 i_clk = ~i_clk;

    clk_div_ctrl dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_start     (i_start),
        .i_stop      (i_stop),
        .i_k_valid   (i_k_valid),
        .i_k         (i_k),
        .o_k_ready   (o_k_ready),
        .o_roll_over (o_roll_over),
        .o_clk_div   (o_clk_div),
        .o_busy      (o_busy)
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
        ,
        .o_period_cnt(o_period_cnt)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: running/stopping flags, position inside current half-period.
    bit m_act, m_stopping, m_level, m_ready, m_roll;
    int m_pos, m_k, m_kp, m_pcnt;

    task automatic model_reset();
        m_act = 0; m_stopping = 0; m_level = 1; m_ready = 1; m_roll = 0;
        m_pos = 0; m_k = 3; m_kp = 3; m_pcnt = 0;
    endtask

    task automatic model_step();
        bit wrap, rise, acc, rdy_n;
        int kval;
        wrap = m_act && (m_pos == m_k - 1);
        rise = wrap && !m_level;
        acc  = i_k_valid && m_ready;
        kval = (int'(i_k) < 2) ? 2 : int'(i_k);
        if (acc && m_act)          rdy_n = 0;
        else if (wrap || !m_act)   rdy_n = 1;
        else                       rdy_n = m_ready;
        if (!m_act || wrap) m_k = m_kp;
        if (acc) m_kp = kval;
        m_ready = rdy_n;
        m_roll  = wrap;
        m_pos   = (m_act && !wrap) ? m_pos + 1 : 0;
        if (wrap) m_level = !m_level;
        if (rise) m_pcnt = (m_pcnt + 1) % 65536;
        if (!m_act) begin
            if (i_start && !i_stop) m_act = 1;
        end else if (!m_stopping) begin
            if (i_stop) m_stopping = 1;
        end else if (rise) begin
            m_act = 0;
            m_stopping = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".roll"},  32'(o_roll_over), 32'(m_roll));
        chk({tag, ".clk"},   32'(o_clk_div),   32'(m_level));
        chk({tag, ".ready"}, 32'(o_k_ready),   32'(m_ready));
        chk({tag, ".busy"},  32'(o_busy),      32'(m_act));
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
        chk({tag, ".pcnt"},  32'(o_period_cnt), 32'(m_pcnt));
`endif
    endtask

    // One clock: model advances on the edge, outputs compared on the falling edge.
    task automatic cyc(input string tag);
        @(posedge i_clk);
        model_step();
        @(negedge i_clk);
        check_all(tag);
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        i_start = 0; i_stop = 0; i_k_valid = 0; i_k = 8'd3;
        @(negedge i_clk);
        model_reset();
        check_all("reset");
        i_reset = 1'b0;
    endtask

    initial begin
        model_reset();
        @(negedge i_clk);
        do_reset();

        // k=3 from reset: pulses at 3,6,9,12; derived clock high for 3, low for 3.
        i_start = 1;
        cyc("start");
        i_start = 0;
        chk("k3.clk0", 32'(o_clk_div), 32'd1);
        for (int c = 1; c <= 13; c++) begin
            cyc("k3");
            chk("k3.roll_at", 32'(o_roll_over), 32'((c % 3) == 0));
            chk("k3.clk_at",  32'(o_clk_div),   32'(((c / 3) % 2) == 0));
        end

        // Ratio change to 5 offered at count 1.
        do_reset();
        i_start = 1;
        cyc("r5.start");
        i_start = 0;
        cyc("r5");
        i_k_valid = 1; i_k = 8'd5;
        for (int c = 2; c <= 14; c++) begin
            cyc("r5");
            i_k_valid = 0;
            if (c == 2) chk("r5.ready_low", 32'(o_k_ready), 32'd0);
            if (c == 3) chk("r5.ready_back", 32'(o_k_ready), 32'd1);
            if (c == 8 || c == 13) chk("r5.roll", 32'(o_roll_over), 32'd1);
        end

        // Stop during the low phase.
        do_reset();
        i_start = 1;
        cyc("stl.start");
        i_start = 0;
        for (int c = 1; c <= 4; c++) cyc("stl");
        i_stop = 1;
        cyc("stl");
        i_stop = 0;
        for (int c = 0; c < 10; c++) cyc("stl");
        chk("stl.busy_end", 32'(o_busy), 32'd0);
        chk("stl.clk_end", 32'(o_clk_div), 32'd1);

        // Stop during the high phase, start during STOP_PEND must not cancel.
        do_reset();
        i_start = 1;
        cyc("sth.start");
        i_start = 0;
        i_stop = 1;
        cyc("sth");
        i_stop = 0; i_start = 1;
        cyc("sth");
        i_start = 0;
        chk("sth.busy_pend", 32'(o_busy), 32'd1);
        for (int c = 0; c < 10; c++) cyc("sth");
        chk("sth.busy_end", 32'(o_busy), 32'd0);

        // k=1 clamps to 2.
        do_reset();
        i_k_valid = 1; i_k = 8'd1;
        cyc("clamp.offer");
        i_k_valid = 0;
        i_start = 1;
        cyc("clamp.start");
        i_start = 0;
        for (int c = 1; c <= 10; c++) begin
            cyc("clamp");
            chk("clamp.roll_at", 32'(o_roll_over), 32'((c % 2) == 0));
        end

        // Asynchronous reset mid-RUN at count 2 in the low phase.
        do_reset();
        i_start = 1;
        cyc("ar.start");
        i_start = 0;
        for (int c = 1; c <= 5; c++) cyc("ar");
        #2 i_reset = 1'b1;
        #1;
        model_reset();
        check_all("ar.async");
        #1 i_reset = 1'b0;
        cyc("ar.idle");
        i_start = 1;
        cyc("ar.restart");
        i_start = 0;
        for (int c = 1; c <= 7; c++) cyc("ar.run");

        // Start and stop together in IDLE; then two full k=3 periods.
        do_reset();
        i_start = 1; i_stop = 1;
        cyc("both");
        i_start = 0; i_stop = 0;
        chk("both.busy", 32'(o_busy), 32'd0);
        i_start = 1;
        cyc("pc.start");
        i_start = 0;
        for (int c = 1; c <= 12; c++) cyc("pc");
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
        chk("pc.two_periods", 32'(o_period_cnt), 32'd2);
`endif

        // Random traffic.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            i_start   = ($urandom % 8) == 0;
            i_stop    = ($urandom % 14) == 0;
            i_k_valid = ($urandom % 5) == 0;
            i_k       = 8'($urandom_range(0, 9));
            cyc("rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
